ysyx_22050039_mem_arb: RTL and testbench
========================================

Name:
ysyx_22050039_mem_arb

Overview:
- Two-requester arbiter sharing the single memory port between the instruction fetch path (IF) and the load/store path (LS).
- One transaction in flight at a time. Each requester uses a valid/ready request channel and a one-cycle response pulse.
- LS has priority; a streak counter prevents IF starvation.
- Sits between the IFU/EXU memory interfaces and the memory/DPI bridge.

Parameters:
- XLEN, 64, address/data width.
- MAX_LS_STREAK, 4, max consecutive LS grants while IF is waiting; range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- if_req_valid  in  1  IF request
- if_req_ready  out  1  IF request accepted this cycle
- if_addr  in  XLEN  IF address (read-only)
- if_rsp_valid  out  1  IF response pulse
- if_rdata  out  XLEN  IF read data
- ls_req_valid  in  1  LS request
- ls_req_ready  out  1  LS request accepted this cycle
- ls_addr  in  XLEN  LS address
- ls_wen  in  1  1 = write, 0 = read
- ls_wdata  in  XLEN  write data
- ls_wmask  in  8  byte-enable mask
- ls_rsp_valid  out  1  LS response pulse (also issued for writes)
- ls_rdata  out  XLEN  LS read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  XLEN  latched address
- mem_wen  out  1  latched write enable
- mem_wdata  out  XLEN  latched write data
- mem_wmask  out  8  latched mask
- mem_rsp_valid  in  1  memory response
- mem_rdata  in  XLEN  memory read data

Behaviour:
- Reset: while rst==0 at a clk edge:
  - state becomes IDLE, owner = none, streak = 0, latched payload = 0.
  - All outputs are 0 in the cycle after that edge.
- States: IDLE, REQ, RSP.
- IDLE arbitration (combinational):
  - Only LS valid: LS wins.
  - Only IF valid: IF wins.
  - Both valid: LS wins if streak < MAX_LS_STREAK, otherwise IF wins.
- IDLE acceptance:
  - The winner's req_ready = 1 in that same cycle; the other requester's req_ready = 0.
  - Payload is latched at the edge.
  - IF transactions force mem_wen = 0 and mem_wmask = 0.
  - State goes to REQ; owner is recorded.
- req_ready is never asserted outside IDLE.
- Streak update, at the acceptance edge:
  - LS granted while IF valid: streak + 1, saturating at 15.
  - IF granted: streak = 0.
  - LS granted while IF not valid: streak = 0.
- REQ:
  - mem_req_valid = 1 and mem_* outputs hold the latched payload, stable until mem_req_ready.
  - If mem_req_ready = 1, go to RSP at the edge.
- RSP:
  - mem_req_valid = 0.
  - When mem_rsp_valid = 1, the owner's rsp_valid = 1 and rdata = mem_rdata in the same cycle (combinational pass-through).
  - The non-owner's rsp_valid stays 0; its rdata is 0.
  - Go to IDLE at that edge.
- Latency:
  - Request accepted at edge N; mem_req_valid is high in cycle N+1.
  - Minimum turnaround is 3 cycles: IDLE→REQ→RSP, with mem_req_ready and mem_rsp_valid each asserted immediately.
  - The next arbitration happens in the IDLE cycle after the response.
- Boundary conditions:
  - mem_rsp_valid in IDLE or REQ is ignored; no rsp pulse is issued.
  - A requester may drop req_valid before acceptance; it is then simply not granted.
  - Payload changes after acceptance do not affect the in-flight transaction.
  - Reset in REQ or RSP drops the transaction: no rsp pulse; IDLE in the next cycle.
  - Both requesters invalid in IDLE: stay in IDLE, streak unchanged.
- No combinational path from mem_req_ready to any req_ready.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with all inputs = 1 → all outputs 0, state IDLE; first grant after release goes to LS.
- Single IF read: if_req_valid = 1, if_addr = 0x80000000; memory gives ready and rsp immediately with rdata = 0x00000413 → if_req_ready in cycle 0, mem_req_valid in cycle 1 with mem_wen = 0, if_rsp_valid with if_rdata = 0x00000413 in cycle 2, ls_rsp_valid = 0 throughout.
- LS write with stalls: addr 0x80001000, wdata 0xdeadbeef, wmask 0x0F; mem_req_ready held low 3 cycles → mem_* stable over 4 cycles; ls_rsp_valid is one pulse on mem_rsp_valid.
- Starvation limit: both valid continuously, MAX_LS_STREAK = 4 → grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
- Payload isolation: change ls_addr to 0x0 one cycle after acceptance of 0x80002000 → mem_addr stays 0x80002000.
- Reset mid-transaction: rst = 0 in RSP, then mem_rsp_valid = 1 → no rsp pulse; a subsequent IF request completes normally.
- Stray response: mem_rsp_valid = 1 in IDLE → no rsp_valid; state stays IDLE.

Source files
------------

// File: rtl/ysyx_22050039_mem_arb.sv
// rtl/ysyx_22050039_mem_arb.sv - IF/LS arbiter for the shared memory port, one transaction in flight
module ysyx_22050039_mem_arb #(
    parameter int XLEN          = 64,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_rsp_valid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            ls_req_valid,
    output logic            ls_req_ready,
    input  logic [XLEN-1:0] ls_addr,
    input  logic            ls_wen,
    input  logic [XLEN-1:0] ls_wdata,
    input  logic [7:0]      ls_wmask,
    output logic            ls_rsp_valid,
    output logic [XLEN-1:0] ls_rdata,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

    state_t            state, state_nxt;
    logic              owner_ls;
    logic [3:0]        streak;
    logic [XLEN-1:0]   lat_addr;
    logic              lat_wen;
    logic [XLEN-1:0]   lat_wdata;
    logic [7:0]        lat_wmask;
    logic              grant_ls, grant_if;
    logic              rsp_pulse;

    always_comb begin
        state_nxt = state;
        grant_ls  = 1'b0;
        grant_if  = 1'b0;
        case (state)
            IDLE: begin
                // LS keeps priority until it has won STREAK_MAX times in a row over a waiting IF
                grant_ls = ls_req_valid && (!if_req_valid || (streak < STREAK_MAX));
                grant_if = if_req_valid && !grant_ls;
                if (grant_ls || grant_if)
                    state_nxt = REQ;
            end
            REQ:     if (mem_req_ready) state_nxt = RSP;
            RSP:     if (mem_rsp_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshakes are masked while reset is asserted so nothing leaks out of a dropped transaction
    assign if_req_ready  = rst && grant_if;
    assign ls_req_ready  = rst && grant_ls;
    assign mem_req_valid = rst && (state == REQ);
    assign rsp_pulse     = rst && (state == RSP) && mem_rsp_valid;
    assign if_rsp_valid  = rsp_pulse && !owner_ls;
    assign ls_rsp_valid  = rsp_pulse && owner_ls;
    assign if_rdata      = if_rsp_valid ? mem_rdata : '0;
    assign ls_rdata      = ls_rsp_valid ? mem_rdata : '0;
    assign mem_addr      = lat_addr;
    assign mem_wen       = lat_wen;
    assign mem_wdata     = lat_wdata;
    assign mem_wmask     = lat_wmask;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            owner_ls  <= 1'b0;
            streak    <= 4'd0;
            lat_addr  <= '0;
            lat_wen   <= 1'b0;
            lat_wdata <= '0;
            lat_wmask <= 8'd0;
        end else begin
            state <= state_nxt;
            if (grant_ls) begin
                owner_ls  <= 1'b1;
                lat_addr  <= ls_addr;
                lat_wen   <= ls_wen;
                lat_wdata <= ls_wdata;
                lat_wmask <= ls_wmask;
                if (!if_req_valid)
                    streak <= 4'd0;
                else if (streak != 4'd15)
                    streak <= streak + 4'd1;
            end else if (grant_if) begin
                owner_ls  <= 1'b0;
                lat_addr  <= if_addr;
                lat_wen   <= 1'b0;
                lat_wdata <= '0;
                lat_wmask <= 8'd0;
                streak    <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050039_mem_arb.sv
// tb/tb_ysyx_22050039_mem_arb.sv - directed self-checking bench for ysyx_22050039_mem_arb
module tb_ysyx_22050039_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [63:0] if_addr, if_rdata;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int passed = 0;
    int total  = 0;
    logic [9:0] order;

    always #5 clk = ~clk;

    ysyx_22050039_mem_arb #(.XLEN(64), .MAX_LS_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        if_req_valid = 1'b1; if_addr = '1;
        ls_req_valid = 1'b1; ls_addr = '1; ls_wen = 1'b1; ls_wdata = '1; ls_wmask = 8'hff;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = '1;

        // reset held two cycles with every input high
        cyc(); cyc();
        #1;
        check("rst_if_ready", if_req_ready, 0);
        check("rst_ls_ready", ls_req_ready, 0);
        check("rst_mem_valid", mem_req_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wmask", mem_wmask, 0);
        check("rst_if_rsp", if_rsp_valid, 0);
        check("rst_ls_rsp", ls_rsp_valid, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_ls_rdata", ls_rdata, 0);
        rst = 1'b1;
        #1;
        check("first_grant_ls", ls_req_ready, 1);
        check("first_grant_if", if_req_ready, 0);
        cyc();
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        #1;
        check("a_req_valid", mem_req_valid, 1);
        check("a_req_wen", mem_wen, 1);
        check("a_req_wmask", mem_wmask, 8'hff);
        check("a_req_ls_rsp", ls_rsp_valid, 0);
        cyc();
        check("a_ls_rsp", ls_rsp_valid, 1);
        check("a_ls_rdata", ls_rdata, 64'hffff_ffff_ffff_ffff);
        check("a_if_rsp", if_rsp_valid, 0);
        cyc();
        // stray response in IDLE
        check("stray_ls_rsp", ls_rsp_valid, 0);
        check("stray_if_rsp", if_rsp_valid, 0);
        check("stray_mem_valid", mem_req_valid, 0);
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        cyc();
        check("idle_stays", mem_req_valid, 0);

        // single IF read with immediate memory
        if_req_valid = 1'b1; if_addr = 64'h8000_0000;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 64'h413;
        #1;
        check("b_if_ready", if_req_ready, 1);
        check("b_ls_ready", ls_req_ready, 0);
        check("b_c0_ls_rsp", ls_rsp_valid, 0);
        cyc();
        if_req_valid = 1'b0;
        #1;
        check("b_mem_valid", mem_req_valid, 1);
        check("b_mem_addr", mem_addr, 64'h8000_0000);
        check("b_mem_wen", mem_wen, 0);
        check("b_mem_wmask", mem_wmask, 0);
        check("b_if_rsp_early", if_rsp_valid, 0);
        check("b_c1_ls_rsp", ls_rsp_valid, 0);
        cyc();
        check("b_if_rsp", if_rsp_valid, 1);
        check("b_if_rdata", if_rdata, 64'h413);
        check("b_c2_ls_rsp", ls_rsp_valid, 0);
        check("b_ls_rdata", ls_rdata, 0);
        cyc();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        #1;
        check("b_if_rsp_once", if_rsp_valid, 0);

        // LS write with three stall cycles; payload inputs change after acceptance
        ls_req_valid = 1'b1; ls_addr = 64'h8000_1000; ls_wen = 1'b1;
        ls_wdata = 64'hdead_beef; ls_wmask = 8'h0f;
        #1;
        check("c_ls_ready", ls_req_ready, 1);
        cyc();
        ls_req_valid = 1'b0; ls_wdata = '0; ls_wmask = 8'hff; ls_wen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_req_ready = 1'b1;
            #1;
            check("c_stall_valid", mem_req_valid, 1);
            check("c_stall_addr", mem_addr, 64'h8000_1000);
            check("c_stall_wdata", mem_wdata, 64'hdead_beef);
            check("c_stall_wmask", mem_wmask, 8'h0f);
            check("c_stall_wen", mem_wen, 1);
            check("c_stall_ls_rsp", ls_rsp_valid, 0);
            cyc();
        end
        mem_req_ready = 1'b0;
        #1;
        check("c_rsp_wait", ls_rsp_valid, 0);
        check("c_rsp_mem_valid", mem_req_valid, 0);
        cyc();
        mem_rsp_valid = 1'b1;
        #1;
        check("c_ls_rsp", ls_rsp_valid, 1);
        cyc();
        mem_rsp_valid = 1'b0;
        #1;
        check("c_ls_rsp_once", ls_rsp_valid, 0);

        // payload isolation on address
        ls_req_valid = 1'b1; ls_addr = 64'h8000_2000; ls_wen = 1'b0;
        #1;
        check("d_ls_ready", ls_req_ready, 1);
        cyc();
        ls_req_valid = 1'b0; ls_addr = '0;
        #1;
        check("d_addr0", mem_addr, 64'h8000_2000);
        cyc();
        check("d_addr1", mem_addr, 64'h8000_2000);
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'h1234;
        #1;
        check("d_ls_rdata", ls_rdata, 64'h1234);
        check("d_if_rdata", if_rdata, 0);
        cyc();
        mem_rsp_valid = 1'b0;

        // reset while in RSP drops the transaction
        if_req_valid = 1'b1; if_addr = 64'h8000_0004; mem_req_ready = 1'b1;
        cyc();
        if_req_valid = 1'b0;
        cyc();
        rst = 1'b0; mem_rsp_valid = 1'b1;
        #1;
        check("e_rst_if_rsp", if_rsp_valid, 0);
        cyc();
        rst = 1'b1;
        #1;
        check("e_after_if_rsp", if_rsp_valid, 0);
        check("e_after_mem_valid", mem_req_valid, 0);
        mem_rsp_valid = 1'b0;
        if_req_valid = 1'b1;
        #1;
        check("e_if_ready", if_req_ready, 1);
        cyc();
        if_req_valid = 1'b0;
        #1;
        check("e_mem_valid", mem_req_valid, 1);
        check("e_mem_addr", mem_addr, 64'h8000_0004);
        cyc();
        mem_rsp_valid = 1'b1; mem_rdata = 64'h5555;
        #1;
        check("e_if_rsp", if_rsp_valid, 1);
        check("e_if_rdata", if_rdata, 64'h5555);
        cyc();
        mem_rsp_valid = 1'b0;

        // starvation limit: grant order LS x4, IF, LS x4, IF (bit g = 1 means LS)
        order = 10'b0111101111;
        if_req_valid = 1'b1; ls_req_valid = 1'b1;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
        for (int g = 0; g < 10; g++) begin
            #1;
            check("f_ls_grant", ls_req_ready, order[g]);
            check("f_if_grant", if_req_ready, !order[g]);
            cyc();
            check("f_no_ready_req", ls_req_ready | if_req_ready, 0);
            cyc();
            check("f_no_ready_rsp", ls_req_ready | if_req_ready, 0);
            cyc();
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
